id_ex_stage_reg: RTL
====================

# id_ex_stage_reg

ID/EX pipeline register of the pipelined RV32I core. It captures decoded operands, immediate, register indices and control bits from ID, and presents them to EX, where the operand 2:1 muxes select between register and immediate values. It supports stall (hold), flush (bubble insertion) and, optionally, registered forwarding-select generation, so that EX forwarding muxes receive their select lines directly from flops.

## Interface
- `XLEN`, 32: datapath width.
- `CTRL_W`, 8: control bundle width. Bit assignment is defined in the shared package.

- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `stall`  in  1: hold all registered contents.
- `flush`  in  1: load a bubble.
- `id_valid`  in  1: ID holds a real instruction.
- `id_pc`  in  XLEN: instruction PC.
- `id_rs1_data`, `id_rs2_data`  in  XLEN: register-file read data.
- `id_imm`  in  XLEN: sign-extended immediate.
- `id_rs1`, `id_rs2`, `id_rd`  in  5: register indices.
- `id_ctrl`  in  CTRL_W: control bundle. Bits: alu_src, reg_write, mem_read, mem_write, mem_to_reg, branch, alu_op[1:0].
- `mem_valid`  in  1: MEM-stage valid.
- `mem_reg_write`  in  1: MEM-stage reg_write.
- `mem_rd`  in  5: MEM-stage destination register.
- `ex_valid`  out  1: EX valid.
- `ex_pc`, `ex_rs1_data`, `ex_rs2_data`, `ex_imm`  out  XLEN: registered copies of the ID inputs.
- `ex_rs1`, `ex_rs2`, `ex_rd`  out  5: registered register indices.
- `ex_ctrl`  out  CTRL_W: registered control bundle.
- `ex_fwd_a`, `ex_fwd_b`  out  2: forwarding selects for operands A and B.
  - 00: register file.
  - 01: EX/MEM result.
  - 10: MEM/WB result.

## Operation
- Update priority at each rising edge, highest first: `rst` > `flush` > `stall` > normal load.
- **Reset:** every output is 0, including `ex_valid`, `ex_ctrl` and both `ex_fwd_*`.
- **Flush (bubble):**
  - `ex_valid`, `ex_ctrl`, `ex_rd` and `ex_fwd_*` are set to 0.
  - Data fields (`pc`, `rs*_data`, `imm`, `rs1`, `rs2`) are also set to 0, so bubbles are deterministic.
- **Stall:** all outputs keep their values. Stall is only asserted when the whole pipeline freezes, so forwarding relationships do not change.
- **Normal load:** every `ex_*` field takes its `id_*` input. `ex_valid` takes `id_valid`.
- If `id_valid`=0 on a normal load, control bits are forced to 0. This makes the slot a bubble regardless of `id_ctrl`.
- **Forwarding select** (loaded in the same cycle as the instruction), shown for `ex_fwd_a` with source `id_rs1`. `ex_fwd_b` uses `id_rs2` identically.
  - 01 if `ex_valid` & `ex_ctrl.reg_write` & `ex_rd`≠0 & `ex_rd`==`id_rs1`. This compares against the instruction currently in EX, which will be in MEM next cycle.
  - Else 10 if `mem_valid` & `mem_reg_write` & `mem_rd`≠0 & `mem_rd`==`id_rs1`. This instruction will be in WB next cycle.
  - Else 00.
  - The EX match has priority over the MEM match, so the newest producer wins.
  - x0 is never forwarded.
- Load-use hazards are not detected here. The hazard unit handles them by asserting `flush` to this block while stalling IF/ID.

## Timing
- Latency is 1 cycle from ID inputs to `ex_*` outputs.
- All outputs come directly from flops; there are no combinational paths from input to output.
- `flush` and `stall` asserted together: flush wins and a bubble is loaded.
- `rst` asserted mid-stall or mid-flush: reset values are loaded on that edge.
- After `rst` deasserts, the first edge with no stall or flush loads ID normally.
- Back-to-back dependent instructions: the second instruction sees `ex_fwd`=01 in its EX cycle.
- A dependency two instructions apart gives 10.

## Configuration
- Macro: `ID_EX_FORWARDING_EN`.
- **Defined:** forwarding-select logic is compiled in as described in Operation.
- **Undefined:**
  - `ex_fwd_a` and `ex_fwd_b` are tied to 2'b00.
  - `mem_valid`, `mem_reg_write` and `mem_rd` remain as ports but are unused.
  - The core then relies on the hazard unit stalling for every RAW dependency.

## Structure
- The shared package `rv_pipe_pkg` holds:
  - control-bit index constants (`CTRL_ALU_SRC`, `CTRL_REG_WRITE`, …);
  - `CTRL_W`;
  - forwarding encodings `FWD_RF`=00, `FWD_EXMEM`=01, `FWD_MEMWB`=10.
- Sub-module `fwd_sel_compare` is combinational and is instantiated twice, once for rs1 and once for rs2.
  - Inputs: source index, EX and MEM rd/reg_write/valid.
  - Output: 2-bit select.
  - It is instantiated only under `ID_EX_FORWARDING_EN`.

## Test plan
- **Reset:** set all `id_*` inputs to nonzero and assert `rst` for 2 cycles, with `stall`=1 on one of them → every output is 0.
- **Load and hold:** load pc=0x100, imm=0xFFFFFFF0, rd=5, ctrl=0x42, then hold `stall` for 3 cycles → outputs keep these exact values for all 3 cycles.
- **Flush priority:** assert `flush` and `stall` together with valid ID data → `ex_valid`=0, `ex_ctrl`=0, `ex_rd`=0 and `ex_fwd`=00 next cycle.
- **EX forward:** load `add x5,…` (reg_write=1) and then `sub x6,x5,x5` → in the second instruction's EX cycle, `ex_fwd_a`=01 and `ex_fwd_b`=01.
- **Priority and WB forward:**
  - With `mem_rd`=7 (valid, reg_write) and EX rd=7, an ID instruction reading rs1=7 gets `ex_fwd_a`=01.
  - With only the MEM match, it gets 10.
  - With rd=0 in both, it gets 00.
- **Macro undefined:** run the EX-forward sequence again → `ex_fwd_a`=`ex_fwd_b`=00 on every cycle.

Source files
------------

// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions for the RV32I core: control-bundle bit map and
// forwarding-select encodings used by the ID/EX register and the EX muxes.
package rv_pipe_pkg;

   localparam int unsigned CTRL_W = 8;

   localparam int unsigned CTRL_ALU_SRC    = 0;
   localparam int unsigned CTRL_REG_WRITE  = 1;
   localparam int unsigned CTRL_MEM_READ   = 2;
   localparam int unsigned CTRL_MEM_WRITE  = 3;
   localparam int unsigned CTRL_MEM_TO_REG = 4;
   localparam int unsigned CTRL_BRANCH     = 5;
   localparam int unsigned CTRL_ALU_OP_LO  = 6;
   localparam int unsigned CTRL_ALU_OP_HI  = 7;

   typedef enum logic [1:0] {
      FWD_RF    = 2'b00,
      FWD_EXMEM = 2'b01,
      FWD_MEMWB = 2'b10
   } fwd_sel_e;

endpackage

// File: rtl/fwd_sel_compare.sv
// Forwarding-select compare for one source operand: picks the newest in-flight
// producer of src_idx_i, never forwarding x0.
module fwd_sel_compare
   import rv_pipe_pkg::*;
(
   input  logic [4:0] src_idx_i,
   input  logic       ex_valid_i,
   input  logic       ex_reg_write_i,
   input  logic [4:0] ex_rd_i,
   input  logic       mem_valid_i,
   input  logic       mem_reg_write_i,
   input  logic [4:0] mem_rd_i,
   output logic [1:0] sel_o
);

   logic ex_hit;
   logic mem_hit;

   always_comb begin
      ex_hit  = ex_valid_i && ex_reg_write_i && (ex_rd_i != 5'd0) && (ex_rd_i == src_idx_i);
      mem_hit = mem_valid_i && mem_reg_write_i && (mem_rd_i != 5'd0) && (mem_rd_i == src_idx_i);
      sel_o   = FWD_RF;
      if (ex_hit) begin
         sel_o = FWD_EXMEM;
      end else if (mem_hit) begin
         sel_o = FWD_MEMWB;
      end
   end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with stall, flush and registered forwarding selects.
// Forwarding-select generation is compiled in only with ID_EX_FORWARDING_EN.
module id_ex_stage_reg
   import rv_pipe_pkg::*;
#(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned CTRL_W = rv_pipe_pkg::CTRL_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [XLEN-1:0]   id_pc,
   input  logic [XLEN-1:0]   id_rs1_data,
   input  logic [XLEN-1:0]   id_rs2_data,
   input  logic [XLEN-1:0]   id_imm,
   input  logic [4:0]        id_rs1,
   input  logic [4:0]        id_rs2,
   input  logic [4:0]        id_rd,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic              mem_valid,
   input  logic              mem_reg_write,
   input  logic [4:0]        mem_rd,
   output logic              ex_valid,
   output logic [XLEN-1:0]   ex_pc,
   output logic [XLEN-1:0]   ex_rs1_data,
   output logic [XLEN-1:0]   ex_rs2_data,
   output logic [XLEN-1:0]   ex_imm,
   output logic [4:0]        ex_rs1,
   output logic [4:0]        ex_rs2,
   output logic [4:0]        ex_rd,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [1:0]        ex_fwd_a,
   output logic [1:0]        ex_fwd_b
);

   logic              valid_d, valid_q;
   logic [XLEN-1:0]   pc_d, pc_q;
   logic [XLEN-1:0]   rs1_data_d, rs1_data_q;
   logic [XLEN-1:0]   rs2_data_d, rs2_data_q;
   logic [XLEN-1:0]   imm_d, imm_q;
   logic [4:0]        rs1_d, rs1_q;
   logic [4:0]        rs2_d, rs2_q;
   logic [4:0]        rd_d, rd_q;
   logic [CTRL_W-1:0] ctrl_d, ctrl_q;
   logic [1:0]        fwd_a_d, fwd_a_q;
   logic [1:0]        fwd_b_d, fwd_b_q;
   logic [1:0]        fwd_a_new;
   logic [1:0]        fwd_b_new;

`ifdef ID_EX_FORWARDING_EN
   // Compare against the instruction now in EX (moves to MEM next cycle).
   fwd_sel_compare u_fwd_a (
      .src_idx_i       (id_rs1),
      .ex_valid_i      (valid_q),
      .ex_reg_write_i  (ctrl_q[CTRL_REG_WRITE]),
      .ex_rd_i         (rd_q),
      .mem_valid_i     (mem_valid),
      .mem_reg_write_i (mem_reg_write),
      .mem_rd_i        (mem_rd),
      .sel_o           (fwd_a_new)
   );

   fwd_sel_compare u_fwd_b (
      .src_idx_i       (id_rs2),
      .ex_valid_i      (valid_q),
      .ex_reg_write_i  (ctrl_q[CTRL_REG_WRITE]),
      .ex_rd_i         (rd_q),
      .mem_valid_i     (mem_valid),
      .mem_reg_write_i (mem_reg_write),
      .mem_rd_i        (mem_rd),
      .sel_o           (fwd_b_new)
   );
`else
   logic unused_mem;
   assign unused_mem = ^{mem_valid, mem_reg_write, mem_rd};
   assign fwd_a_new  = FWD_RF;
   assign fwd_b_new  = FWD_RF;
`endif

   always_comb begin
      valid_d    = valid_q;
      pc_d       = pc_q;
      rs1_data_d = rs1_data_q;
      rs2_data_d = rs2_data_q;
      imm_d      = imm_q;
      rs1_d      = rs1_q;
      rs2_d      = rs2_q;
      rd_d       = rd_q;
      ctrl_d     = ctrl_q;
      fwd_a_d    = fwd_a_q;
      fwd_b_d    = fwd_b_q;
      if (flush) begin
         valid_d    = 1'b0;
         pc_d       = '0;
         rs1_data_d = '0;
         rs2_data_d = '0;
         imm_d      = '0;
         rs1_d      = '0;
         rs2_d      = '0;
         rd_d       = '0;
         ctrl_d     = '0;
         fwd_a_d    = FWD_RF;
         fwd_b_d    = FWD_RF;
      end else if (!stall) begin
         valid_d    = id_valid;
         pc_d       = id_pc;
         rs1_data_d = id_rs1_data;
         rs2_data_d = id_rs2_data;
         imm_d      = id_imm;
         rs1_d      = id_rs1;
         rs2_d      = id_rs2;
         rd_d       = id_rd;
         // An invalid ID slot becomes a bubble whatever the decoder produced.
         ctrl_d     = id_valid ? id_ctrl : '0;
         fwd_a_d    = fwd_a_new;
         fwd_b_d    = fwd_b_new;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q    <= 1'b0;
         pc_q       <= '0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         imm_q      <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         rd_q       <= '0;
         ctrl_q     <= '0;
         fwd_a_q    <= FWD_RF;
         fwd_b_q    <= FWD_RF;
      end else begin
         valid_q    <= valid_d;
         pc_q       <= pc_d;
         rs1_data_q <= rs1_data_d;
         rs2_data_q <= rs2_data_d;
         imm_q      <= imm_d;
         rs1_q      <= rs1_d;
         rs2_q      <= rs2_d;
         rd_q       <= rd_d;
         ctrl_q     <= ctrl_d;
         fwd_a_q    <= fwd_a_d;
         fwd_b_q    <= fwd_b_d;
      end
   end

   assign ex_valid    = valid_q;
   assign ex_pc       = pc_q;
   assign ex_rs1_data = rs1_data_q;
   assign ex_rs2_data = rs2_data_q;
   assign ex_imm      = imm_q;
   assign ex_rs1      = rs1_q;
   assign ex_rs2      = rs2_q;
   assign ex_rd       = rd_q;
   assign ex_ctrl     = ctrl_q;
   assign ex_fwd_a    = fwd_a_q;
   assign ex_fwd_b    = fwd_b_q;

endmodule
